uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_sync2.sv | 22 ++
 rtl/uart_rx.sv | 124 ++++++++++++
 tb/tb_uart_rx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding.
// The transmitter uses the same constants.
package uart_pkg;
  localparam int CLKS_PER_BIT_DEFAULT = 414;
  localparam int UART_DATA_BITS       = 8;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input.
// Reset forces the output to the line-idle level.
module uart_sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_s1, r_s2;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a one-entry valid/ready holding
// register. Framing errors and overruns are reported as one-cycle pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 CLKIN,
  input  logic                 RESETN,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun
);
  localparam int H     = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 w_rxs;
  rx_state_t            r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_done, r_valid, r_fe, r_ov;

  uart_sync2 u_sync (
    .i_clk   (CLKIN),
    .i_rst_n (RESETN),
    .i_d     (rx),
    .o_q     (w_rxs)
  );

  always_ff @(posedge CLKIN) begin
    if (!RESETN) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_fe    <= 1'b0;
      r_ov    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_fe   <= 1'b0;
      r_ov   <= 1'b0;

      // A completed byte lands one cycle after the stop-bit sample; a
      // simultaneous accept frees the slot on that same edge.
      if (r_done) begin
        if (!r_valid || ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ov <= 1'b1;
        end
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (!w_rxs) r_state <= START;
        end
        START: begin
          if (r_cnt == CNT_HALF) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= w_rxs ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
            if (r_idx == IDX_LAST) begin
              r_idx   <= '0;
              r_state <= STOP;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            if (w_rxs) begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_fe    <= 1'b1;
              r_state <= BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        BREAK: begin
          r_cnt <= '0;
          if (w_rxs) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_fe;
  assign overrun   = r_ov;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: byte reception, false
// start, framing error/break, overrun, simultaneous accept, reset mid-frame.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int N = 16;

  logic       CLKIN = 1'b0;
  logic       RESETN = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, frame_err, overrun;

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int vld_rise = 0, vld_hi = 0, fe_cnt = 0, ov_cnt = 0, rise_cyc = 0;
  logic pv = 1'b0;

  uart_rx #(.CLKS_PER_BIT(N), .DATA_BITS(8)) dut (
    .CLKIN     (CLKIN),
    .RESETN    (RESETN),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 CLKIN = ~CLKIN;

  always @(posedge CLKIN) cyc <= cyc + 1;

  // Event monitor sampled shortly after each rising edge.
  always begin
    @(posedge CLKIN);
    #2;
    if (valid === 1'b1 && pv !== 1'b1) begin
      vld_rise = vld_rise + 1;
      rise_cyc = cyc;
    end
    if (valid === 1'b1) vld_hi = vld_hi + 1;
    if (frame_err === 1'b1) fe_cnt = fe_cnt + 1;
    if (overrun === 1'b1) ov_cnt = ov_cnt + 1;
    pv = valid;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLKIN);
  endtask

  // Caller is at a falling edge; line is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    idle(N);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(N);
    end
    rx = stop;
    idle(N);
  endtask

  task automatic test_reset();
    RESETN = 1'b0; rx = 1'b1; ready = 1'b0;
    idle(3);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 0", data); end
    checks++; if (valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got v=%b fe=%b ov=%b expected 0 0 0", valid, frame_err, overrun);
    end
    RESETN = 1'b1;
    idle(3);
  endtask

  task automatic test_byte_a5();
    int c, r0, h0, f0, o0;
    ready = 1'b1;
    c = cyc; r0 = vld_rise; h0 = vld_hi; f0 = fe_cnt; o0 = ov_cnt;
    send_frame(8'hA5, 1'b1);
    idle(10);
    checks++; if (data !== 8'hA5) begin errors++; $display("FAIL a5_data: got %0h expected a5", data); end
    checks++; if (vld_rise - r0 != 1 || rise_cyc != c + 156) begin
      errors++; $display("FAIL a5_latency: rises=%0d at %0d expected 1 at %0d", vld_rise - r0, rise_cyc, c + 156);
    end
    checks++; if (vld_hi - h0 != 1) begin errors++; $display("FAIL a5_valid_width: got %0d expected 1", vld_hi - h0); end
    checks++; if (fe_cnt != f0 || ov_cnt != o0) begin
      errors++; $display("FAIL a5_flags: got fe=%0d ov=%0d expected 0 0", fe_cnt - f0, ov_cnt - o0);
    end
  endtask

  task automatic test_false_start();
    int c, r0, f0;
    c = cyc; r0 = vld_rise; f0 = fe_cnt;
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(5);
    checks++; if (dut.r_state !== START) begin errors++; $display("FAIL fs_in_start: got %0d expected START", dut.r_state); end
    idle(1);
    checks++; if (dut.r_state !== IDLE) begin errors++; $display("FAIL fs_back_idle: got %0d expected IDLE", dut.r_state); end
    idle(30);
    checks++; if (vld_rise != r0 || fe_cnt != f0) begin
      errors++; $display("FAIL fs_no_events: got rises=%0d fe=%0d expected 0 0", vld_rise - r0, fe_cnt - f0);
    end
    send_frame(8'h3C, 1'b1);
    idle(4);
    checks++; if (data !== 8'h3C || vld_rise - r0 != 1) begin
      errors++; $display("FAIL fs_next_frame: got %0h rises=%0d expected 3c 1", data, vld_rise - r0);
    end
  endtask

  task automatic test_frame_err();
    int r0, f0;
    r0 = vld_rise; f0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    idle(100);
    checks++; if (fe_cnt - f0 != 1) begin errors++; $display("FAIL fe_count: got %0d expected 1", fe_cnt - f0); end
    checks++; if (vld_rise != r0) begin errors++; $display("FAIL fe_no_valid: got %0d expected 0", vld_rise - r0); end
    rx = 1'b1;
    idle(5);
    send_frame(8'h81, 1'b1);
    idle(4);
    checks++; if (data !== 8'h81 || vld_rise - r0 != 1 || fe_cnt - f0 != 1) begin
      errors++; $display("FAIL fe_recover: got %0h rises=%0d fe=%0d expected 81 1 1", data, vld_rise - r0, fe_cnt - f0);
    end
  endtask

  task automatic test_back_to_back_overrun();
    int o0;
    ready = 1'b0;
    o0 = ov_cnt;
    send_frame(8'h11, 1'b1);
    checks++; if (valid !== 1'b1 || data !== 8'h11) begin
      errors++; $display("FAIL ov_first: got v=%b d=%0h expected 1 11", valid, data);
    end
    send_frame(8'h22, 1'b1);
    idle(2);
    checks++; if (ov_cnt - o0 != 1) begin errors++; $display("FAIL ov_pulse: got %0d expected 1", ov_cnt - o0); end
    checks++; if (valid !== 1'b1 || data !== 8'h11) begin
      errors++; $display("FAIL ov_keep: got v=%b d=%0h expected 1 11", valid, data);
    end
    ready = 1'b1;
    idle(1);
    ready = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ov_drain: got %b expected 0", valid); end
  endtask

  task automatic test_simul_accept();
    int o0;
    ready = 1'b0;
    send_frame(8'h33, 1'b1);
    idle(2);
    checks++; if (valid !== 1'b1 || data !== 8'h33) begin
      errors++; $display("FAIL sim_first: got v=%b d=%0h expected 1 33", valid, data);
    end
    o0 = ov_cnt;
    fork
      send_frame(8'h22, 1'b1);
      begin
        idle(155);
        ready = 1'b1;
        idle(1);
        ready = 1'b0;
      end
    join
    idle(2);
    checks++; if (valid !== 1'b1 || data !== 8'h22 || ov_cnt != o0) begin
      errors++; $display("FAIL sim_accept: got v=%b d=%0h ov=%0d expected 1 22 0", valid, data, ov_cnt - o0);
    end
    ready = 1'b1;
    idle(1);
  endtask

  task automatic test_reset_mid();
    int r0;
    ready = 1'b1;
    r0 = vld_rise;
    fork
      send_frame(8'hF0, 1'b1);
      begin
        idle(72);
        RESETN = 1'b0;
        idle(1);
        RESETN = 1'b1;
        checks++; if (valid !== 1'b0 || data !== 8'h00 || frame_err !== 1'b0 || overrun !== 1'b0) begin
          errors++; $display("FAIL rst_mid_outputs: got v=%b d=%0h fe=%b ov=%b expected 0 0 0 0", valid, data, frame_err, overrun);
        end
        checks++; if (dut.r_state !== IDLE) begin errors++; $display("FAIL rst_mid_state: got %0d expected IDLE", dut.r_state); end
      end
    join
    idle(40);
    checks++; if (vld_rise != r0) begin errors++; $display("FAIL rst_mid_no_valid: got %0d expected 0", vld_rise - r0); end
    send_frame(8'hF0, 1'b1);
    idle(4);
    checks++; if (data !== 8'hF0 || vld_rise - r0 != 1) begin
      errors++; $display("FAIL rst_mid_next: got %0h rises=%0d expected f0 1", data, vld_rise - r0);
    end
  endtask

  initial begin
    idle(1);
    test_reset();
    test_byte_a5();
    test_false_start();
    test_frame_err();
    test_back_to_back_overrun();
    test_simul_accept();
    test_reset_mid();
    idle(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
